// File: rtl/filtro_pkg.sv
// Shared definitions for the filtro RAM filter sequencer: filter mode codes and FSM states.
package filtro_pkg;

  localparam logic [1:0] MODE_PASS   = 2'd0;
  localparam logic [1:0] MODE_SMOOTH = 2'd1;
  localparam logic [1:0] MODE_EDGE   = 2'd2;
  localparam logic [1:0] MODE_INV    = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_WAIT  = 3'd2,
    ST_WRITE = 3'd3,
    ST_FIN   = 3'd4
  } filtro_state_e;

endpackage

// File: rtl/filtro_kernel3.sv
// Combinational causal 3-tap kernel: a = x[i-2], b = x[i-1], c = x[i].
module filtro_kernel3
  import filtro_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  input  logic [DATA_W-1:0] c_i,
  input  logic [1:0]        mode_i,
  output logic [DATA_W-1:0] y_o
);

  logic [DATA_W+1:0] sum;
  logic [DATA_W:0]   diff;
  logic [DATA_W:0]   diff_abs;

  // Two guard bits keep a+2b+c exact; one extra bit makes the difference sign visible.
  assign sum      = {2'b00, a_i} + {1'b0, b_i, 1'b0} + {2'b00, c_i};
  assign diff     = {1'b0, c_i} - {1'b0, a_i};
  assign diff_abs = diff[DATA_W] ? -diff : diff;

  always_comb begin
    y_o = c_i;
    unique case (mode_i)
      MODE_PASS:   y_o = c_i;
      MODE_SMOOTH: y_o = DATA_W'(sum >> 2);
      MODE_EDGE:   y_o = DATA_W'(diff_abs);
      MODE_INV:    y_o = ~c_i;
      default:     y_o = c_i;
    endcase
  end

endmodule

// File: rtl/filtro_ram_seq.sv
// RAM-to-RAM 3-tap filter sequencer (READ/WAIT/WRITE per sample).
// Optional cycle counter enabled by defining FILTRO_PERF_EN.
module filtro_ram_seq
  import filtro_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 32,
  parameter int LEN_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_base,
  input  logic [ADDR_W-1:0] dst_base,
  input  logic [LEN_W-1:0]  length,
  input  logic [1:0]        mode,
  output logic              mem_RE,
  output logic              mem_WE,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              done,
  output logic [31:0]       cycle_count
);

  filtro_state_e state_q, state_d;

  logic [ADDR_W-1:0] src_q, dst_q;
  logic [LEN_W-1:0]  len_q, idx_q;
  logic [1:0]        mode_q;
  logic [DATA_W-1:0] a_q, b_q, c_q;
  logic [DATA_W-1:0] kernel_y;
  logic              accept;
  logic              last_idx;

  assign accept   = (state_q == ST_IDLE) && start;
  assign last_idx = (idx_q == len_q - LEN_W'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (start) state_d = (length == '0) ? ST_FIN : ST_READ;
      ST_READ:  state_d = ST_WAIT;
      ST_WAIT:  state_d = ST_WRITE;
      ST_WRITE: state_d = last_idx ? ST_FIN : ST_READ;
      ST_FIN:   state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    mem_RE    = 1'b0;
    mem_WE    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    busy      = 1'b0;
    done      = 1'b0;
    unique case (state_q)
      ST_READ: begin
        mem_RE   = 1'b1;
        mem_addr = src_q + ADDR_W'(idx_q);
        busy     = 1'b1;
      end
      ST_WAIT: busy = 1'b1;
      ST_WRITE: begin
        mem_WE    = 1'b1;
        mem_addr  = dst_q + ADDR_W'(idx_q);
        mem_wdata = kernel_y;
        busy      = 1'b1;
      end
      ST_FIN:  done = 1'b1;
      default: ;
    endcase
  end

  // Window: first sample is replicated into a and b so the filter sees a flat history.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src_q  <= '0;
      dst_q  <= '0;
      len_q  <= '0;
      mode_q <= MODE_PASS;
      idx_q  <= '0;
      a_q    <= '0;
      b_q    <= '0;
      c_q    <= '0;
    end else begin
      if (accept) begin
        src_q  <= src_base;
        dst_q  <= dst_base;
        len_q  <= length;
        mode_q <= mode;
        idx_q  <= '0;
      end
      if (state_q == ST_WAIT) begin
        c_q <= mem_rdata;
        if (idx_q == '0) begin
          a_q <= mem_rdata;
          b_q <= mem_rdata;
        end
      end
      if (state_q == ST_WRITE) begin
        a_q   <= b_q;
        b_q   <= c_q;
        idx_q <= idx_q + LEN_W'(1);
      end
    end
  end

  filtro_kernel3 #(.DATA_W(DATA_W)) u_kernel (
    .a_i    (a_q),
    .b_i    (b_q),
    .c_i    (c_q),
    .mode_i (mode_q),
    .y_o    (kernel_y)
  );

`ifdef FILTRO_PERF_EN
  logic [31:0] cnt_q;

  // Counts every non-idle cycle including FIN; saturates instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                                cnt_q <= '0;
    else if (accept)                                           cnt_q <= '0;
    else if ((state_q != ST_IDLE) && (cnt_q != 32'hFFFF_FFFF)) cnt_q <= cnt_q + 32'd1;
  end

  assign cycle_count = cnt_q;
`else
  assign cycle_count = '0;
`endif

endmodule

// File: doc/filtro_ram_seq.md
Name: filtro_ram_seq

Overview:
- Parametrised successor of the fixed 8-bit RAM filter processor.
- Autonomous sequencer: on `start`, streams LENGTH samples from RAM at SRC_BASE through a selectable causal 3-tap filter, writing results to DST_BASE.
- Sample width, address width and length width are generic; four runtime filter modes.
- Sits between the control logic and the single-port data RAM, driving the same RE/WE/address/data interface.

Parameters:
- DATA_W, 8, sample width in bits.
- ADDR_W, 32, RAM address width.
- LEN_W, 16, width of the transfer length field.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- src_base  in  ADDR_W  first read address; latched on accepted start.
- dst_base  in  ADDR_W  first write address; latched on accepted start.
- length  in  LEN_W  sample count; latched on accepted start.
- mode  in  2  0 pass, 1 smooth, 2 edge, 3 invert; latched on accepted start.
- mem_RE  out  1  RAM read strobe.
- mem_WE  out  1  RAM write strobe.
- mem_addr  out  ADDR_W  RAM address.
- mem_wdata  out  DATA_W  RAM write data.
- mem_rdata  in  DATA_W  RAM read data; valid the cycle after mem_RE.
- busy  out  1  high from accepted start until done.
- done  out  1  one-cycle completion pulse.
- cycle_count  out  32  performance counter (see Optional Feature).

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; window registers a, b, c = 0; internal index = 0.
- FSM states: IDLE, READ, WAIT, WRITE, FIN.
- IDLE:
  - start=1 latches src_base, dst_base, length, mode and sets busy=1.
  - Goes to FIN if length==0, else READ.
  - start is ignored in every other state.
- READ: mem_RE=1, mem_addr=src+idx. Next state WAIT.
- WAIT: capture mem_rdata into c.
  - If idx==0, also load a=b=mem_rdata (edge replication).
  - Next state WRITE.
- WRITE:
  - mem_WE=1, mem_addr=dst+idx, mem_wdata=f(a,b,c).
  - Then shift a<=b, b<=c and increment idx.
  - If idx==length-1, go to FIN; else go to READ.
- FIN: done=1 for exactly one cycle, busy=0, return to IDLE.
- Throughput: 3 cycles per sample. A run of N>0 samples takes 3N+1 cycles from the start edge to the done pulse.
- Filter f (a=x[i-2], b=x[i-1], c=x[i]):
  - Mode 0: c.
  - Mode 1: (a+2b+c)>>2, computed in DATA_W+2 bits, then truncated (never overflows).
  - Mode 2: |c-a|, computed in DATA_W+1 bits.
  - Mode 3: (2^DATA_W-1)-c.
- Addresses: src+idx and dst+idx wrap modulo 2^ADDR_W with no error.
- length = 2^LEN_W-1 is legal.
- mem_RE and mem_WE are never high in the same cycle.
- mem_addr and mem_wdata are 0 whenever their strobe is low.
- In-place operation (src==dst) is legal. Each read precedes the write to the same address, and results are causal, so output is correct.
- Async reset mid-run: strobes drop immediately, no done pulse, FSM returns to IDLE. The next start begins a fresh run.

Optional Feature:
- Macro: FILTRO_PERF_EN.
- Defined:
  - cycle_count clears on accepted start.
  - Increments each cycle busy=1, including the FIN cycle.
  - Holds its value after done until the next start.
  - Saturates at 2^32-1.
- Undefined: cycle_count tied to 0; no counter flops synthesised.

Decomposition:
- Package filtro_pkg holds:
  - Mode encodings MODE_PASS=0, MODE_SMOOTH=1, MODE_EDGE=2, MODE_INV=3.
  - FSM state enum/constants.
- One natural sub-module: filtro_kernel3, purely combinational, computing f(a,b,c,mode) with DATA_W parameter. Sequencer, window and FSM stay in the top.

Test Plan:
- Mode 1, DATA_W=8, RAM[0..3]={8,16,32,64}, src=0, dst=100, length=4 -> RAM[100..103]={8,10,18,36}; done pulses 13 cycles after start; busy high throughout.
- Mode 2 on {10,50,20,200}, then mode 3 on {0,255,7} -> writes {0,40,10,150}, then {255,0,248}.
- length=0 -> no RE/WE ever; done one cycle after start; cycle_count=1 with FILTRO_PERF_EN.
- Second start pulsed while busy, plus in-place run (src=dst=0xFFFFFFFE, length=3) -> second start ignored; addresses wrap to 0xFFFFFFFE, 0xFFFFFFFF, 0x00000000; results correct.
- rst_n low during a WAIT cycle -> mem_RE/mem_WE fall asynchronously; no done pulse; a fresh mode 0 run of {1,2} afterwards copies {1,2} exactly.
- Without FILTRO_PERF_EN, cycle_count stays 0 across all runs. With the macro, a 4-sample run reads 13.
